seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 2-bit-state FSM detector in the lab FSM set.
- Pattern width, overlap mode and Mealy/Moore output timing are selected by parameters.
- The pattern is loaded at run time rather than hard-coded.
- Adds input qualification (`in_valid`) and a saturating match counter.
- Used as the serial-stream front end in the FSM lab designs.

Parameters:
- `PAT_W`, 4: pattern length in bits; legal range 2..16.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = after a match, detection restarts from an empty prefix.
- `MEALY`, 0: 0 = registered (Moore) `z`; 1 = combinational (Mealy) `z`.
- `CNT_W`, 8: width of `match_count`.
- `Y_W`, `$clog2(PAT_W)`: derived width of the state output `y`.

Ports:
- `clk`, input, 1: clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-high reset.
- `x1`, input, 1: serial data bit, sampled when `in_valid`=1.
- `in_valid`, input, 1: qualifies `x1`; when 0, no state change occurs.
- `load`, input, 1: loads `pattern_in` and restarts detection.
- `pattern_in`, input, `PAT_W`: new pattern; bit `PAT_W-1` is the first bit expected.
- `y`, output, `Y_W`: current state = length of the matched prefix, 0..`PAT_W-1`.
- `z`, output, 1: match indication (timing per `MEALY`).
- `match_count`, output, `CNT_W`: number of matches since reset; saturating.

Behaviour:
- **Reset:** `reset`=1 at posedge gives `y`=0, registered `z`=0, `match_count`=0, pattern register=0. Reset has priority over `load` and `in_valid`, and applies mid-stream: any partial prefix is discarded.
- **Load:** `load`=1 at posedge (no reset) writes the pattern register from `pattern_in`, forces `y`=0 and registered `z`=0. `match_count` is unchanged. `in_valid` is ignored on that edge.
- **State (y):** length of the longest pattern prefix that is a suffix of the bits accepted since the last restart (KMP-style), never equal to `PAT_W`.
- **Step rule** on posedge with `in_valid`=1, with current state `k` and bit `b`:
  - `k'` = longest `j` ≤ `k`+1 such that the first `j` pattern bits equal the last `j` received bits (the `k` prefix bits followed by `b`).
  - If `k'` < `PAT_W`: `y` <= `k'`, no match.
  - If `k'` = `PAT_W`: match. `y` <= border length (longest proper prefix of the pattern that is also a suffix) when `OVERLAP`=1; `y` <= 0 when `OVERLAP`=0.
- **Transition logic:** computed combinationally from the pattern register, the current `y` and `x1`. No per-pattern tables are precomputed at load time, and no extra latency is added.
- **MEALY=0:** `z` is a register, set to 1 on the edge that accepts the final matching bit and held for exactly one cycle. Consecutive matching edges keep it high. It is cleared on any edge without a match, including edges with `in_valid`=0.
- **MEALY=1:** `z` = `in_valid` & (step rule yields `k'` = `PAT_W`) in the current cycle, combinational from `x1`/`in_valid`/`y`. It is forced to 0 while `reset` or `load` is high.
- **match_count:** increments by 1 on each matching edge. It saturates at 2^`CNT_W`-1 and does not wrap.
- **`in_valid`=0:** `y`, the pattern and `match_count` hold.
- **Pattern reload mid-stream:** the old partial match is discarded; there is no match on the load edge.
- **Patterns** are treated literally: all-0 and all-1 patterns are legal. With `OVERLAP`=1, an all-ones pattern of width `PAT_W` matches on every accepted 1 once `PAT_W` ones have been received.
- **Outputs** never go X after the first reset edge.

Test Plan:
- **Overlap match:** `PAT_W`=4, `OVERLAP`=1, `MEALY`=0, load 4'b1001, stream 1,0,0,1,0,0,1 (`in_valid`=1 every cycle) -> `y` sequence 1,2,3,1,2,3,1; `z`=1 for one cycle after the 4th and 7th bits; `match_count`=2.
- **Non-overlap:** same setup with `OVERLAP`=0 -> `y` sequence 1,2,3,0,0,0,1; `z` pulses only after the 4th bit; `match_count`=1.
- **Mealy timing + gaps:** `MEALY`=1, pattern 1001; hold `in_valid`=0 for 3 cycles between bits 2 and 3 -> `y` holds at 2 during the gap; `z` is high combinationally in the same cycle `x1`=1 is presented with `y`=3 and `in_valid`=1; `z`=0 whenever `in_valid`=0.
- **Reset/load mid-operation:** stream 1,0,0, then assert `reset` one cycle -> `y`=0, `z`=0, `match_count`=0; next bit 1 gives `y`=1. Repeat with `load` (pattern 4'b0110) instead of `reset` -> `y`=0, `match_count` unchanged, and 0,1,1,0 then matches.
- **Saturation:** `CNT_W`=2, pattern 4'b1111, `OVERLAP`=1, 8 consecutive 1s -> matches on bits 4..8 (5 matches); `match_count` goes 1,2,3,3,3.
- **Simultaneous controls:** `reset`=1 and `load`=1 on the same edge -> reset wins, pattern register=0. `load`=1 with `in_valid`=1 and a completing bit -> no match, `z`=0, `y`=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Serial bit-pattern detector with a run-time loadable pattern. The state y is
//   the length of the longest pattern prefix that ends the accepted bit stream
//   (KMP-style), derived combinationally from the pattern register, y and x1.
//   Bits are accepted only when in_valid is high. Matches are counted in a
//   saturating counter.
//
// Parameters
//   PAT_W   : pattern length (2..16); pattern_in[PAT_W-1] is the first bit.
//   OVERLAP : 1 = a match continues from the pattern border, 0 = from empty.
//   MEALY   : 0 = registered z, 1 = combinational z.
//   CNT_W   : width of match_count.
//   Y_W     : width of y.
//
// Ports
//   clk         : clock, all state updates on posedge
//   reset       : synchronous active-high reset (highest priority)
//   x1          : serial data bit
//   in_valid    : qualifies x1; no state change when low
//   load        : load pattern_in and restart detection
//   pattern_in  : new pattern
//   y           : matched prefix length, 0..PAT_W-1
//   z           : match indication
//   match_count : saturating number of matches since reset
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int PAT_W   = 4,
  parameter int OVERLAP = 1,
  parameter int MEALY   = 0,
  parameter int CNT_W   = 8,
  parameter int Y_W     = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x1,
  input  logic             in_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  output logic [Y_W-1:0]   y,
  output logic             z,
  output logic [CNT_W-1:0] match_count
);

  // One extra bit so the k prefix bits plus the new bit always fit.
  localparam int V_W = PAT_W + 1;

  // Longest j <= k+1 such that the first j pattern bits equal the last j bits
  // of (the k matched prefix bits followed by b). Prefixes are read from the
  // top of the pattern by shifting right; the candidate string is built with
  // the newest bit at the LSB so "last j bits" is a simple mask.
  function automatic int step_len(input logic [PAT_W-1:0] pat,
                                  input logic [Y_W-1:0]   k,
                                  input logic             b);
    logic [V_W-1:0] pv;
    logic [V_W-1:0] rcv;
    logic [V_W-1:0] mask;
    int             kk;
    int             best;
    pv   = {1'b0, pat};
    kk   = int'(k);
    rcv  = ((pv >> (PAT_W - kk)) << 1) | V_W'(b);
    best = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      mask = (V_W'(1) << j) - V_W'(1);
      if ((j <= kk + 1) && ((rcv & mask) == (pv >> (PAT_W - j))))
        best = j;
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int border_len(input logic [PAT_W-1:0] pat);
    logic [V_W-1:0] pv;
    logic [V_W-1:0] mask;
    int             best;
    pv   = {1'b0, pat};
    best = 0;
    for (int j = 1; j < PAT_W; j++) begin
      mask = (V_W'(1) << j) - V_W'(1);
      if ((pv & mask) == (pv >> (PAT_W - j)))
        best = j;
    end
    return best;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match;
  int               k_nxt;

  always_comb begin
    pat_d = pat_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    match = 1'b0;
    k_nxt = step_len(pat_q, y_q, x1);
    if (reset) begin
      // Register update handled in the sequential block; only gate the match.
      match = 1'b0;
    end else if (load) begin
      pat_d = pattern_in;
      y_d   = '0;
    end else if (in_valid) begin
      if (k_nxt == PAT_W) begin
        match = 1'b1;
        cnt_d = sat_inc(cnt_q);
        y_d   = (OVERLAP != 0) ? Y_W'(border_len(pat_q)) : '0;
      end else begin
        y_d   = Y_W'(k_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= '0;
      y_q   <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  generate
    if (MEALY != 0) begin : g_mealy
      assign z = match;
    end else begin : g_moore
      logic z_q;
      always_ff @(posedge clk) begin
        if (reset) z_q <= 1'b0;
        else       z_q <= match;
      end
      assign z = z_q;
    end
  endgenerate

  assign y           = y_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Four detector instances (PAT_W=4) share one stimulus stream:
//     d0: OVERLAP=1 MEALY=0 CNT_W=2   d1: OVERLAP=0 MEALY=0 CNT_W=8
//     d2: OVERLAP=1 MEALY=1 CNT_W=8   d3: OVERLAP=0 MEALY=1 CNT_W=3
//   The reference keeps the last accepted bits since restart and derives the
//   expected prefix length and match directly from string comparisons.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_s = 1'b1;
  logic       x1_s = 1'b0;
  logic       vld_s = 1'b0;
  logic       load_s = 1'b0;
  logic [3:0] pat_s = 4'b0000;

  logic [1:0] y0, y1, y2, y3;
  logic       z0, z1, z2, z3;
  logic [1:0] c0;
  logic [7:0] c1;
  logic [7:0] c2;
  logic [2:0] c3;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .OVERLAP(1), .MEALY(0), .CNT_W(2)) d0 (
    .clk(clk), .reset(reset_s), .x1(x1_s), .in_valid(vld_s), .load(load_s),
    .pattern_in(pat_s), .y(y0), .z(z0), .match_count(c0));
  seq_detector_param #(.PAT_W(4), .OVERLAP(0), .MEALY(0), .CNT_W(8)) d1 (
    .clk(clk), .reset(reset_s), .x1(x1_s), .in_valid(vld_s), .load(load_s),
    .pattern_in(pat_s), .y(y1), .z(z1), .match_count(c1));
  seq_detector_param #(.PAT_W(4), .OVERLAP(1), .MEALY(1), .CNT_W(8)) d2 (
    .clk(clk), .reset(reset_s), .x1(x1_s), .in_valid(vld_s), .load(load_s),
    .pattern_in(pat_s), .y(y2), .z(z2), .match_count(c2));
  seq_detector_param #(.PAT_W(4), .OVERLAP(0), .MEALY(1), .CNT_W(3)) d3 (
    .clk(clk), .reset(reset_s), .x1(x1_s), .in_valid(vld_s), .load(load_s),
    .pattern_in(pat_s), .y(y3), .z(z3), .match_count(c3));

  int OVL  [4] = '{1, 0, 1, 0};
  int MLY  [4] = '{0, 0, 1, 1};
  int CMAX [4] = '{3, 255, 255, 7};

  logic [3:0] m_pat [4];
  logic [3:0] m_h   [4];   // last accepted bits, newest at bit 0
  int         m_len [4];   // how many of m_h are valid (0..4)
  int         m_cnt [4];
  bit         m_hit [4];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Longest j<4 whose pattern prefix equals the last j accepted bits.
  function automatic int exp_y(input int d);
    int best = 0;
    for (int j = 0; j < 4; j++) begin
      if (j <= m_len[d] &&
          ((int'(m_h[d]) & ((1 << j) - 1)) == (int'(m_pat[d]) >> (4 - j))))
        best = j;
    end
    return best;
  endfunction

  task automatic model_edge(input int d, input bit r, input bit l,
                            input bit v, input bit x, input logic [3:0] p);
    m_hit[d] = 1'b0;
    if (r) begin
      m_pat[d] = 4'b0000; m_h[d] = 4'b0000; m_len[d] = 0; m_cnt[d] = 0;
    end else if (l) begin
      m_pat[d] = p; m_h[d] = 4'b0000; m_len[d] = 0;
    end else if (v) begin
      m_h[d] = {m_h[d][2:0], x};
      if (m_len[d] < 4) m_len[d]++;
      if (m_len[d] == 4 && m_h[d] == m_pat[d]) begin
        m_hit[d] = 1'b1;
        if (m_cnt[d] < CMAX[d]) m_cnt[d]++;
        if (OVL[d] == 0) begin
          m_h[d] = 4'b0000; m_len[d] = 0;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit l, input bit v, input bit x,
                       input logic [3:0] p);
    int ay [4];
    int az [4];
    int ac [4];
    reset_s = r; load_s = l; vld_s = v; x1_s = x; pat_s = p;
    @(negedge clk);
    for (int d = 0; d < 4; d++) model_edge(d, r, l, v, x, p);
    check("mealy_z2", int'(z2), int'(m_hit[2]));
    check("mealy_z3", int'(z3), int'(m_hit[3]));
    @(posedge clk);
    #1;
    ay = '{int'(y0), int'(y1), int'(y2), int'(y3)};
    az = '{int'(z0), int'(z1), int'(z2), int'(z3)};
    ac = '{int'(c0), int'(c1), int'(c2), int'(c3)};
    for (int d = 0; d < 4; d++) begin
      check($sformatf("y_d%0d", d), ay[d], exp_y(d));
      check($sformatf("cnt_d%0d", d), ac[d], m_cnt[d]);
      if (MLY[d] == 0)
        check($sformatf("moore_z_d%0d", d), az[d], int'(m_hit[d]));
    end
  endtask

  task automatic bits(input logic [7:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b0, 1'b1, seq[i], 4'b0000);
  endtask

  initial begin
    logic [3:0] rp;
    // Reset state
    cycle(1, 0, 0, 0, 4'b0000);
    cycle(1, 0, 1, 1, 4'b1111);
    check("rst_y0", int'(y0), 0);
    check("rst_cnt0", int'(c0), 0);

    // Overlap / non-overlap on 1001 with stream 1001001
    cycle(0, 1, 0, 0, 4'b1001);
    bits(8'b0100_1001, 7);
    check("ovl_cnt_d2", int'(c2), 2);
    check("novl_cnt_d1", int'(c1), 1);
    check("ovl_y_d0", int'(y0), 1);
    check("novl_y_d1", int'(y1), 1);

    // Gap of 3 invalid cycles between bits 2 and 3
    cycle(1, 0, 0, 0, 4'b0000);
    cycle(0, 1, 0, 0, 4'b1001);
    bits(8'b0000_0010, 2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 4'b0000);
    check("gap_y_d2", int'(y2), 2);
    bits(8'b0000_0001, 2);
    check("gap_cnt_d2", int'(c2), 1);

    // Reset mid-stream
    cycle(1, 0, 0, 0, 4'b0000);
    cycle(0, 1, 0, 0, 4'b1001);
    bits(8'b0000_0100, 3);
    cycle(1, 0, 1, 1, 4'b0000);
    check("midrst_y0", int'(y0), 0);
    cycle(0, 1, 0, 0, 4'b1001);
    bits(8'b0000_0001, 1);
    check("midrst_next_y0", int'(y0), 1);

    // Load mid-stream
    bits(8'b0000_0000, 2);
    cycle(0, 1, 1, 1, 4'b0110);
    check("midload_y1", int'(y1), 0);
    bits(8'b0000_0110, 4);
    check("midload_cnt_d1", int'(c1), 1);

    // Saturation with all-ones pattern
    cycle(1, 0, 0, 0, 4'b0000);
    cycle(0, 1, 0, 0, 4'b1111);
    bits(8'b1111_1111, 8);
    check("sat_cnt_d0", int'(c0), 3);
    check("sat_cnt_d2", int'(c2), 5);
    check("sat_cnt_d3", int'(c3), 2);

    // Simultaneous reset+load: reset wins, pattern becomes 0000
    cycle(1, 1, 1, 1, 4'b1010);
    bits(8'b0000_0000, 4);
    check("rstload_cnt_d2", int'(c2), 1);

    // Load together with a completing bit: no match
    cycle(1, 0, 0, 0, 4'b0000);
    cycle(0, 1, 0, 0, 4'b1001);
    bits(8'b0000_0100, 3);
    cycle(0, 1, 1, 1, 4'b1001);
    check("loadhit_z0", int'(z0), 0);
    check("loadhit_y0", int'(y0), 0);
    check("loadhit_cnt_d0", int'(c0), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       rp = 4'b0000;
        1:       rp = 4'b1111;
        default: rp = 4'($urandom_range(0, 15));
      endcase
      cycle(($urandom_range(0, 127) == 0), ($urandom_range(0, 47) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
